// File: rtl/conv_pkg.sv
// Shared definitions for the conv stream controller: FSM encoding and
// frame-size derivations from the feature-map side length.
package conv_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Pixels per frame.
   function automatic int frame_len(input int d);
      return d * d;
   endfunction

   // Valid 3x3 outputs per frame.
   function automatic int out_total(input int d);
      return (d - 2) * (d - 2);
   endfunction

endpackage

// File: rtl/conv_stream_ctrl.sv
// Streams one D x D frame from a buffer into the conv engine, counts engine
// outputs, and reports completion or a drain timeout.
module conv_stream_ctrl
   import conv_pkg::*;
#(
   parameter int D          = 9,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int DRAIN_MAX  = 32
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    start,
   input  logic [ADDR_WIDTH-1:0]                   base_addr,
   input  logic                                    hold,
   output logic                                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                   mem_addr,
   input  logic [DATA_WIDTH-1:0]                   mem_rd_data,
   output logic                                    valid_in,
   output logic [DATA_WIDTH-1:0]                   pxl_in,
   input  logic                                    valid_out,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    error,
   output logic [$clog2(out_total(D)+1)-1:0]       out_count
);

   localparam int T     = frame_len(D);
   localparam int OUT_T = out_total(D);
   localparam int CNT_W = $clog2(T);
   localparam int OUT_W = $clog2(OUT_T + 1);
   localparam int DRN_W = $clog2(DRAIN_MAX + 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        fetch_cnt_q, fetch_cnt_d;
   logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
   logic [OUT_W-1:0]        out_cnt_q, out_cnt_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic                    error_q, error_d;
   logic                    valid_in_q, valid_in_d;
   logic [DATA_WIDTH-1:0]   pxl_q, pxl_d;

   always_comb begin
      state_d     = state_q;
      fetch_cnt_d = fetch_cnt_q;
      drain_cnt_d = drain_cnt_q;
      out_cnt_d   = out_cnt_q;
      base_d      = base_q;
      error_d     = error_q;
      mem_rd_en   = 1'b0;
      mem_addr    = '0;

      if ((state_q == S_FETCH || state_q == S_DRAIN) && valid_out &&
          out_cnt_q != OUT_W'(OUT_T))
         out_cnt_d = out_cnt_q + OUT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_FETCH;
               fetch_cnt_d = '0;
               drain_cnt_d = '0;
               out_cnt_d   = '0;
               error_d     = 1'b0;
               base_d      = base_addr;
            end
         end
         S_FETCH: begin
            if (!hold) begin
               mem_rd_en   = 1'b1;
               mem_addr    = base_q + ADDR_WIDTH'(fetch_cnt_q);
               fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
               if (fetch_cnt_q == CNT_W'(T - 1)) begin
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + DRN_W'(1);
            // Completion wins over a timeout landing on the same cycle.
            if (out_cnt_q == OUT_W'(OUT_T)) begin
               state_d = S_DONE;
            end else if (drain_cnt_q == DRN_W'(DRAIN_MAX - 1)) begin
               state_d = S_DONE;
               error_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      valid_in_d = mem_rd_en;
      // Read data arrives the cycle after the strobe, alongside valid_in.
      pxl_d      = valid_in_q ? mem_rd_data : pxl_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         fetch_cnt_q <= '0;
         drain_cnt_q <= '0;
         out_cnt_q   <= '0;
         base_q      <= '0;
         error_q     <= 1'b0;
         valid_in_q  <= 1'b0;
         pxl_q       <= '0;
      end else begin
         state_q     <= state_d;
         fetch_cnt_q <= fetch_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         out_cnt_q   <= out_cnt_d;
         base_q      <= base_d;
         error_q     <= error_d;
         valid_in_q  <= valid_in_d;
         pxl_q       <= pxl_d;
      end
   end

   assign valid_in  = valid_in_q;
   assign pxl_in    = pxl_d;
   assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign error     = error_q;
   assign out_count = out_cnt_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl: a cycle-arithmetic reference model
// checked every cycle, plus hand-computed per-frame expectations.
module tb_conv_stream_ctrl;
   import conv_pkg::*;

   localparam int D = 9, DW = 32, AW = 7, DM = 32;
   localparam int T = 81, OT = 49;
   localparam int OCW = $clog2(out_total(D) + 1);

   logic clk = 1'b0;
   logic reset, start, hold = 1'b0, valid_out;
   logic [AW-1:0] base_addr, mem_addr;
   logic mem_rd_en, valid_in, busy, done, error;
   logic [DW-1:0] mem_rd_data, pxl_in;
   logic [OCW-1:0] out_count;

   conv_stream_ctrl #(.D(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DRAIN_MAX(DM)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .hold(hold),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .valid_in(valid_in), .pxl_in(pxl_in), .valid_out(valid_out), .busy(busy),
      .done(done), .error(error), .out_count(out_count));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Buffer contents and a registered-read buffer; garbage when not read.
   logic [DW-1:0] gmem [128];
   always @(posedge clk) mem_rd_data <= mem_rd_en ? gmem[mem_addr] : 32'hDEADBEEF;

   // Engine: one valid_out per pixel with row>=2 and col>=2, up to eng_max.
   int eng_k = 0, eng_sent = 0, eng_max = OT;
   bit eng_clr = 1'b1, force_vo = 1'b0;
   always @(posedge clk) begin
      if (eng_clr) begin
         eng_k <= 0; eng_sent <= 0; valid_out <= 1'b0;
      end else if (valid_in === 1'b1) begin
         eng_k <= eng_k + 1;
         if (eng_k / D >= 2 && eng_k % D >= 2 && eng_sent < eng_max) begin
            valid_out <= 1'b1; eng_sent <= eng_sent + 1;
         end else valid_out <= force_vo;
      end else valid_out <= force_vo;
   end

   int s_cyc = 0, frame_seq = 0;
   bit hold_mode = 1'b0;
   // Hold every third fetch cycle (fetch index 2, 5, 8, ...).
   always @(posedge clk) begin
      #1;
      hold = hold_mode && (cyc > s_cyc) && ((cyc - s_cyc) % 3 == 0);
   end

   // Reference model and per-frame observations.
   bit m_armed = 1'b0, m_in, m_err, m_prev_rd;
   int m_left, m_E, m_C, m_von, seen_seq = 0;
   logic [AW-1:0] m_base, m_prev_addr;
   logic [DW-1:0] m_last;
   int o_vi, o_first_vi, o_done, o_done_cyc;
   logic [AW-1:0] o_addr [$];

   always @(negedge clk) begin
      bit e_rd, e_done, e_busy, fin, tmo;
      int dc;
      logic [AW-1:0] e_addr;
      if (seen_seq != frame_seq) begin
         seen_seq = frame_seq;
         o_vi = 0; o_first_vi = -1; o_done = 0; o_done_cyc = -1; o_addr.delete();
      end
      if (m_armed) begin
         e_rd   = m_in && m_left > 0 && !hold;
         e_addr = m_base + AW'(T - m_left);
         fin = 1'b0; tmo = 1'b0;
         if (m_in && m_E >= 0) begin
            dc = (m_C >= 0) ? ((m_C > m_E ? m_C : m_E) + 1) : (1 << 30);
            if (dc <= m_E + DM) fin = (cyc == dc);
            else tmo = (cyc == m_E + DM);
         end
         e_done = fin || tmo;
         if (tmo) m_err = 1'b1;
         e_busy = m_in && !e_done;
         chk("rd_en", mem_rd_en, e_rd);
         if (e_rd) chk("addr", mem_addr, e_addr);
         chk("valid_in", valid_in, m_prev_rd);
         chk("pxl_in", pxl_in, m_prev_rd ? gmem[m_prev_addr] : m_last);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("error", error, m_err);
         chk("out_count", out_count, (m_von > OT) ? OT : m_von);
         if (valid_in === 1'b1) begin
            if (o_vi == 0) o_first_vi = cyc;
            o_vi++;
         end
         if (mem_rd_en === 1'b1) o_addr.push_back(mem_addr);
         if (done === 1'b1) begin o_done++; o_done_cyc = cyc; end
         if (m_prev_rd) m_last = gmem[m_prev_addr];
         m_prev_rd = e_rd; m_prev_addr = e_addr;
      end
      if (reset) begin
         m_armed = 1'b1; m_in = 1'b0; m_err = 1'b0; m_prev_rd = 1'b0; m_left = 0;
         m_E = -1; m_C = -1; m_von = 0; m_base = '0; m_prev_addr = '0; m_last = '0;
      end else if (m_armed) begin
         if (e_rd) begin m_left--; if (m_left == 0) m_E = cyc + 1; end
         if (e_busy && valid_out === 1'b1) begin m_von++; if (m_von == OT) m_C = cyc + 1; end
         if (!m_in && start) begin
            m_in = 1'b1; m_left = T; m_E = -1; m_C = -1; m_von = 0; m_err = 1'b0;
            m_base = base_addr;
         end else if (e_done) m_in = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_frame(input logic [AW-1:0] b);
      @(posedge clk); #1;
      base_addr = b; start = 1'b1; eng_clr = 1'b1; s_cyc = cyc; frame_seq++;
      @(posedge clk); #1;
      start = 1'b0; eng_clr = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (o_done == 0 && k < budget) begin tick(1); k++; end
      chk("done_within_budget", (o_done > 0), 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0;
      for (int i = 0; i < 128; i++) gmem[i] = 32'hA000_0000 | (i * 37 + 5);
      tick(3);
      chk("rst_outputs", {mem_rd_en, mem_addr, valid_in, pxl_in, busy, done, error, out_count}, 0);
      reset = 1'b0; eng_clr = 1'b0;
      tick(2);

      // Plain frame from address 0.
      start_frame(0);
      wait_done(200);
      chk("f1_first_vi_lat", o_first_vi - s_cyc, 2);
      chk("f1_vi_count", o_vi, 81);
      chk("f1_addr_first", o_addr[0], 0);
      chk("f1_addr_last", o_addr[80], 80);
      chk("f1_done_cyc", o_done_cyc - s_cyc, 85);
      chk("f1_out_count", out_count, 49);
      chk("f1_error", error, 0);
      // valid_out in IDLE must not move out_count.
      tick(2); force_vo = 1'b1; tick(1); force_vo = 1'b0; tick(3);
      chk("idle_vo_ignored", out_count, 49);

      // Address wrap from 120.
      start_frame(120);
      wait_done(200);
      chk("f2_addr0", o_addr[0], 120);
      chk("f2_addr7", o_addr[7], 127);
      chk("f2_addr8", o_addr[8], 0);
      chk("f2_addr80", o_addr[80], 72);
      chk("f2_vi_count", o_vi, 81);

      // Hold on every third fetch cycle.
      hold_mode = 1'b1;
      start_frame(5);
      wait_done(300);
      hold_mode = 1'b0;
      chk("f3_vi_count", o_vi, 81);
      chk("f3_fetch_count", o_addr.size(), 81);
      chk("f3_done_cyc", o_done_cyc - s_cyc, 125);

      // Engine starves at 40 outputs: drain timeout.
      eng_max = 40;
      start_frame(0);
      wait_done(300);
      chk("f4_error", error, 1);
      chk("f4_done_cyc", o_done_cyc - s_cyc, 82 + DM);
      chk("f4_out_count", out_count, 40);
      eng_max = OT;
      start_frame(0);
      chk("f5_error_cleared", error, 0);
      wait_done(200);
      chk("f5_done_cyc", o_done_cyc - s_cyc, 85);

      // start during FETCH is ignored.
      start_frame(10);
      tick(9); start = 1'b1; tick(1); start = 1'b0;
      wait_done(200);
      tick(100);
      chk("f6_done_pulses", o_done, 1);
      chk("f6_vi_count", o_vi, 81);
      chk("f6_idle", busy, 0);

      // Reset during the 30th fetch.
      start_frame(0);
      tick(29); reset = 1'b1; tick(1);
      chk("f7_rst_outputs", {mem_rd_en, mem_addr, valid_in, pxl_in, busy, done, error, out_count}, 0);
      reset = 1'b0;
      tick(20);
      chk("f7_no_done", o_done, 0);
      start_frame(3);
      wait_done(200);
      chk("f8_vi_count", o_vi, 81);
      chk("f8_addr_last", o_addr[80], 83);
      chk("f8_done_cyc", o_done_cyc - s_cyc, 85);
      chk("f8_out_count", out_count, 49);

      tick(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
